// File: rtl/fiber_req_arbiter.sv
// Purpose : round-robin arbiter sharing one fiberBank request port between NUM_PE PEs; READ/CONSUME IDs kept in an in-order tag FIFO to steer responses back.
// Latency : PE accepted at edge N -> registered bank command valid from cycle N+1; response path is combinational from bank inputs and FIFO head.
// Backpr. : bank command held stable until i_type_ready; READ/CONSUME skipped while RSP_DEPTH outstanding; bank response stalled by head PE's rready.
// Ports   : i_pe_* / o_pe_ready  per-PE request side (packed NUM_PE lanes)
//           o_pe_r* / i_pe_rready response back to PEs (rdata broadcast, rvalid one-hot)
//           o_request_type/o_addr/o_data/o_type_valid/i_type_ready  bank request
//           i_bank_rdata/i_bank_rvalid/o_bank_rready  bank response; o_illegal drop pulse
module fiber_req_arbiter #(
    parameter int NUM_PE     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [4*NUM_PE-1:0]          i_pe_request_type,
    input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
    input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_data,
    input  logic [NUM_PE-1:0]            i_pe_valid,
    output logic [NUM_PE-1:0]            o_pe_ready,
    output logic [DATA_WIDTH-1:0]        o_pe_rdata,
    output logic [NUM_PE-1:0]            o_pe_rvalid,
    input  logic [NUM_PE-1:0]            i_pe_rready,
    output logic                         o_illegal,
    output logic [3:0]                   o_request_type,
    output logic [ADDR_WIDTH-1:0]        o_addr,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_type_valid,
    input  logic                         i_type_ready,
    input  logic [DATA_WIDTH-1:0]        i_bank_rdata,
    input  logic                         i_bank_rvalid,
    output logic                         o_bank_rready
);
    localparam int IDW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int AW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam logic [IDW:0]  NPE       = (IDW + 1)'(NUM_PE);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RSP_DEPTH);
    localparam logic [3:0]    T_READ    = 4'b0010;
    localparam logic [3:0]    T_CONSUME = 4'b1000;

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic logic is_tagged(input logic [3:0] t);
        return (t == T_READ) || (t == T_CONSUME);
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_PE - 1)) ? '0 : id + 1'b1;
    endfunction

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]             cmd_type_q, cmd_type_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0]  cmd_data_q, cmd_data_d;
    logic [IDW-1:0]         cmd_id_q, cmd_id_d;
    logic                   illegal_q, illegal_d;
    logic [IDW-1:0]         tag_mem_q [RSP_DEPTH];
    logic [IDW-1:0]         tag_mem_d [RSP_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   fifo_full, fifo_empty, push, pop;
    logic [IDW-1:0]         head_id;
    logic [NUM_PE-1:0]      elig;
    logic                   grant_vld;
    logic [IDW-1:0]         grant_id;
    logic [IDW:0]           scan_idx;
    logic [3:0]             win_type;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_data;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = tag_mem_q[rd_ptr_q];

    // A READ/CONSUME needs a free tag slot; everything else (incl. illegal) may always go.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            elig[k] = i_pe_valid[k] & ~(fifo_full & is_tagged(i_pe_request_type[4*k +: 4]));
        end
    end

    // First eligible PE at or after rr_ptr, modulo NUM_PE.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
            if (scan_idx >= NPE) begin
                scan_idx = scan_idx - NPE;
            end
            if (!grant_vld && elig[scan_idx[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx[IDW-1:0];
            end
        end
        // No acceptance while a command is pending or while reset is asserted.
        if (i_reset || (state_q != IDLE)) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        win_type   = '0;
        win_addr   = '0;
        win_data   = '0;
        o_pe_ready = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (grant_id == IDW'(k)) begin
                win_type      = i_pe_request_type[4*k +: 4];
                win_addr      = i_pe_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
                win_data      = i_pe_data[DATA_WIDTH*k +: DATA_WIDTH];
                o_pe_ready[k] = grant_vld;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cmd_type_d = cmd_type_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_id_d   = cmd_id_q;
        illegal_d  = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    if ($onehot(win_type)) begin
                        cmd_type_d = win_type;
                        cmd_addr_d = win_addr;
                        cmd_data_d = win_data;
                        cmd_id_d   = grant_id;
                        state_d    = ISSUE;
                    end else begin
                        // Accepted and dropped; pointer moves on so the offender does not hog the port.
                        illegal_d = 1'b1;
                        rr_ptr_d  = next_id(grant_id);
                    end
                end
            end
            ISSUE: begin
                if (i_type_ready) begin
                    push     = is_tagged(cmd_type_q);
                    rr_ptr_d = next_id(cmd_id_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response steering: only the oldest outstanding requester may take bank data.
    always_comb begin
        o_pe_rvalid   = '0;
        o_bank_rready = 1'b0;
        if (!fifo_empty) begin
            o_pe_rvalid[head_id] = i_bank_rvalid;
            o_bank_rready        = i_pe_rready[head_id];
        end
    end

    assign o_pe_rdata = i_bank_rdata;
    assign pop        = i_bank_rvalid & o_bank_rready;

    always_comb begin
        tag_mem_d = tag_mem_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = cmd_id_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cmd_type_q <= '0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            cmd_id_q   <= '0;
            illegal_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int j = 0; j < RSP_DEPTH; j++) begin
                tag_mem_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cmd_type_q <= cmd_type_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            cmd_id_q   <= cmd_id_d;
            illegal_q  <= illegal_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tag_mem_q  <= tag_mem_d;
        end
    end

    assign o_type_valid   = (state_q == ISSUE);
    assign o_request_type = cmd_type_q;
    assign o_addr         = cmd_addr_q;
    assign o_data         = cmd_data_q;
    assign o_illegal      = illegal_q;

endmodule

// File: tb/tb_fiber_req_arbiter.sv
// Bench for fiber_req_arbiter: directed stimulus, per-cycle comparison against a
// transaction-level model (pending command + tag queue), plus literal spot checks.
module tb_fiber_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 64;
    localparam int RD = 4;
    localparam logic [3:0] FETCH = 4'b0001, READ = 4'b0010, WRITE = 4'b0100, CONSUME = 4'b1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    typ [N];
    logic [AW-1:0] adr [N];
    logic [DW-1:0] dat [N];
    logic [N-1:0]  vld;
    logic [N-1:0]  rrdy;
    logic          type_rdy;
    logic [DW-1:0] bank_rdata;
    logic          bank_rvalid;

    logic [4*N-1:0]  typ_p;
    logic [AW*N-1:0] adr_p;
    logic [DW*N-1:0] dat_p;

    logic [N-1:0]  o_pe_ready, o_pe_rvalid;
    logic [DW-1:0] o_pe_rdata, o_data;
    logic          o_illegal, o_type_valid, o_bank_rready;
    logic [3:0]    o_request_type;
    logic [AW-1:0] o_addr;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            typ_p[4*k +: 4]   = typ[k];
            adr_p[AW*k +: AW] = adr[k];
            dat_p[DW*k +: DW] = dat[k];
        end
    end

    fiber_req_arbiter #(.NUM_PE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_pe_request_type(typ_p), .i_pe_addr(adr_p), .i_pe_data(dat_p),
        .i_pe_valid(vld), .o_pe_ready(o_pe_ready),
        .o_pe_rdata(o_pe_rdata), .o_pe_rvalid(o_pe_rvalid), .i_pe_rready(rrdy),
        .o_illegal(o_illegal),
        .o_request_type(o_request_type), .o_addr(o_addr), .o_data(o_data),
        .o_type_valid(o_type_valid), .i_type_ready(type_rdy),
        .i_bank_rdata(bank_rdata), .i_bank_rvalid(bank_rvalid), .o_bank_rready(o_bank_rready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_rd(input logic [3:0] t);
        return (t == READ) || (t == CONSUME);
    endfunction

    // ---------------- transaction-level model ----------------
    bit            model_on = 1'b0;
    bit            m_busy = 1'b0;
    int            m_rr = 0;
    bit            m_ill = 1'b0;
    int            m_tags [$];
    int            m_pid = 0;
    logic [3:0]    m_ptype = '0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pdata = '0;
    int            grant_log [$];

    always @(negedge clk) begin : cmp
        int         w;
        int         idx;
        int         push_id;
        bit         do_pop;
        bit         nxt_ill;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic       e_brdy;
        if (model_on) begin
            w = -1;
            if (!rst && !m_busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (w < 0 && vld[idx] && !(is_rd(typ[idx]) && m_tags.size() == RD)) w = idx;
                end
            end
            e_rdy = '0;
            if (w >= 0) e_rdy[w] = 1'b1;
            e_rv   = '0;
            e_brdy = 1'b0;
            if (m_tags.size() > 0) begin
                e_rv[m_tags[0]] = bank_rvalid;
                e_brdy          = rrdy[m_tags[0]];
            end

            chk("pe_ready", 64'(o_pe_ready), 64'(e_rdy));
            chk("type_valid", 64'(o_type_valid), 64'(m_busy));
            if (m_busy) begin
                chk("req_type", 64'(o_request_type), 64'(m_ptype));
                chk("req_addr", o_addr, m_paddr);
                chk("req_data", 64'(o_data), 64'(m_pdata));
            end
            chk("illegal", 64'(o_illegal), 64'(m_ill));
            chk("pe_rvalid", 64'(o_pe_rvalid), 64'(e_rv));
            chk("bank_rready", 64'(o_bank_rready), 64'(e_brdy));
            if (m_tags.size() > 0 && bank_rvalid) chk("pe_rdata", 64'(o_pe_rdata), 64'(bank_rdata));

            for (int k = 0; k < N; k++) if (o_pe_ready[k]) grant_log.push_back(k);

            // advance model to the state after the coming rising edge
            if (rst) begin
                m_busy = 1'b0; m_rr = 0; m_ill = 1'b0; m_tags.delete();
            end else begin
                do_pop  = (m_tags.size() > 0) && bank_rvalid && rrdy[m_tags[0]];
                push_id = -1;
                nxt_ill = 1'b0;
                if (!m_busy) begin
                    if (w >= 0) begin
                        if ($onehot(typ[w])) begin
                            m_busy = 1'b1; m_pid = w;
                            m_ptype = typ[w]; m_paddr = adr[w]; m_pdata = dat[w];
                        end else begin
                            nxt_ill = 1'b1;
                            m_rr    = (w + 1) % N;
                        end
                    end
                end else if (type_rdy) begin
                    if (is_rd(m_ptype)) push_id = m_pid;
                    m_rr   = (m_pid + 1) % N;
                    m_busy = 1'b0;
                end
                if (do_pop) void'(m_tags.pop_front());
                if (push_id >= 0) m_tags.push_back(push_id);
                m_ill = nxt_ill;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic probe();
        @(negedge clk); #1;
    endtask

    task automatic wait_ready(input int k, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            probe();
            if (o_pe_ready[k]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pops;
        rst = 1'b1; type_rdy = 1'b1; rrdy = '1;
        bank_rdata = '0; bank_rvalid = 1'b0; vld = '1;
        for (int k = 0; k < N; k++) begin
            typ[k] = WRITE;
            adr[k] = 64'hA000_0000_0000_0000 + 64'(k * 16'h0110);
            dat[k] = 16'h1000 + 16'(k);
        end
        tick();
        model_on = 1'b1;

        // reset with all PEs valid
        for (int c = 0; c < 3; c++) begin
            probe();
            chk("rst_pe_ready", 64'(o_pe_ready), 64'h0);
            chk("rst_type_valid", 64'(o_type_valid), 64'h0);
            chk("rst_addr", o_addr, 64'h0);
            chk("rst_type", 64'(o_request_type), 64'h0);
            chk("rst_illegal", 64'(o_illegal), 64'h0);
            chk("rst_bank_rready", 64'(o_bank_rready), 64'h0);
            tick();
        end
        rst = 1'b0;
        grant_log.delete();
        probe();
        chk("first_grant_pe0", 64'(o_pe_ready), 64'h1);

        // round robin, all WRITE, bank always ready
        for (int c = 0; c < 9; c++) tick();
        chk("rr_count", 64'(grant_log.size() >= 5), 64'd1);
        chk("rr_g0", 64'(grant_log[0]), 64'd0);
        chk("rr_g1", 64'(grant_log[1]), 64'd1);
        chk("rr_g2", 64'(grant_log[2]), 64'd2);
        chk("rr_g3", 64'(grant_log[3]), 64'd3);
        chk("rr_g4", 64'(grant_log[4]), 64'd0);
        vld = '0;
        tick();

        // backpressure: PE1 command held 5 cycles, PE2 waiting
        vld[1] = 1'b1;
        wait_ready(1, 10, "bp_grant_pe1");
        tick();
        vld[1] = 1'b0; vld[2] = 1'b1; type_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            probe();
            chk("bp_valid", 64'(o_type_valid), 64'd1);
            chk("bp_addr", o_addr, 64'hA000_0000_0000_0110);
            chk("bp_data", 64'(o_data), 64'h1001);
            chk("bp_no_grant", 64'(o_pe_ready), 64'h0);
            tick();
        end
        type_rdy = 1'b1;
        probe();
        chk("bp_release_valid", 64'(o_type_valid), 64'd1);
        tick();
        probe();
        chk("bp_next_pe2", 64'(o_pe_ready), 64'h4);
        tick();
        vld = '0;
        tick();

        // response routing: PE2 READ then PE1 CONSUME
        typ[2] = READ; vld[2] = 1'b1;
        wait_ready(2, 10, "rsp_grant_pe2");
        tick();
        vld[2] = 1'b0; typ[1] = CONSUME; vld[1] = 1'b1;
        wait_ready(1, 10, "rsp_grant_pe1");
        tick();
        vld[1] = 1'b0;
        tick(); tick();
        bank_rvalid = 1'b1; bank_rdata = 16'hAAAA; rrdy = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            probe();
            chk("rsp_stall_rvalid", 64'(o_pe_rvalid), 64'h4);
            chk("rsp_stall_brdy", 64'(o_bank_rready), 64'h0);
            chk("rsp_stall_rdata", 64'(o_pe_rdata), 64'hAAAA);
            tick();
        end
        rrdy = '1;
        probe();
        chk("rsp1_rvalid", 64'(o_pe_rvalid), 64'h4);
        chk("rsp1_brdy", 64'(o_bank_rready), 64'h1);
        tick();
        bank_rdata = 16'h5555;
        probe();
        chk("rsp2_rvalid", 64'(o_pe_rvalid), 64'h2);
        chk("rsp2_rdata", 64'(o_pe_rdata), 64'h5555);
        tick();
        probe();
        chk("stray_brdy", 64'(o_bank_rready), 64'h0);
        chk("stray_rvalid", 64'(o_pe_rvalid), 64'h0);
        tick();
        bank_rvalid = 1'b0;

        // fill tag FIFO with PE0 READs
        typ[0] = READ; vld[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        probe();
        chk("full_skip_pe0", 64'(o_pe_ready), 64'h0);
        tick();
        typ[1] = WRITE; vld[1] = 1'b1;
        probe();
        chk("full_write_pe1", 64'(o_pe_ready), 64'h2);
        tick();
        vld[1] = 1'b0;
        tick();
        bank_rvalid = 1'b1;
        probe();
        chk("full_still_skip", 64'(o_pe_ready), 64'h0);
        chk("full_pop_rvalid", 64'(o_pe_rvalid), 64'h1);
        tick();
        bank_rvalid = 1'b0;
        probe();
        chk("after_pop_pe0", 64'(o_pe_ready), 64'h1);
        tick();
        vld[0] = 1'b0; bank_rvalid = 1'b1;
        probe();
        chk("pushpop_valid", 64'(o_type_valid), 64'h1);
        chk("pushpop_brdy", 64'(o_bank_rready), 64'h1);
        tick();
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            probe();
            if (o_bank_rready && bank_rvalid) pops++;
            tick();
        end
        chk("drain_count", 64'(pops), 64'd3);
        bank_rvalid = 1'b0;

        // illegal type from PE3
        typ[3] = 4'b0110; vld[3] = 1'b1;
        probe();
        chk("ill_ready", 64'(o_pe_ready), 64'h8);
        tick();
        vld[3] = 1'b0; typ[0] = WRITE; typ[1] = WRITE; vld[0] = 1'b1; vld[1] = 1'b1;
        probe();
        chk("ill_pulse", 64'(o_illegal), 64'h1);
        chk("ill_no_issue", 64'(o_type_valid), 64'h0);
        chk("ill_rr_pe0", 64'(o_pe_ready), 64'h1);
        tick();
        vld = '0;
        probe();
        chk("ill_pulse_end", 64'(o_illegal), 64'h0);
        tick(); tick();

        // reset while a command is pending
        vld[2] = 1'b1; typ[2] = WRITE; type_rdy = 1'b0;
        wait_ready(2, 10, "mid_grant_pe2");
        tick();
        vld[2] = 1'b0;
        probe();
        chk("mid_pending", 64'(o_type_valid), 64'h1);
        tick();
        rst = 1'b1;
        tick();
        probe();
        chk("mid_rst_valid", 64'(o_type_valid), 64'h0);
        chk("mid_rst_addr", o_addr, 64'h0);
        tick();
        rst = 1'b0; type_rdy = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
